// File: rtl/wb_commit_regfile.sv
// Clocked architectural register file with EX/WB handshake, dual write ports,
// stack-pointer auto-adjust, pending-write scoreboard and bypassed decode reads.
module wb_commit_regfile #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned SP_IDX  = 4,
    parameter int unsigned SP_STEP = 8,
    parameter int unsigned PEND_W  = 2,
    parameter int unsigned IDX_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic                    wa_en,
    input  logic [IDX_W-1:0]        wa_idx,
    input  logic [DATA_W-1:0]       wa_data,
    input  logic                    wb_en,
    input  logic [IDX_W-1:0]        wb_idx,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [1:0]              sp_adj,
    input  logic                    store_done,
    input  logic                    sim_end,
    input  logic                    iss_valid,
    input  logic [IDX_W-1:0]        iss_idx,
    output logic                    iss_stall,
    input  logic [IDX_W-1:0]        rd0_idx,
    input  logic [IDX_W-1:0]        rd1_idx,
    output logic [DATA_W-1:0]       rd0_data,
    output logic [DATA_W-1:0]       rd1_data,
    output logic                    rd0_busy,
    output logic                    rd1_busy,
    output logic                    store_commit,
    output logic                    halted,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [DATA_W-1:0] regs     [NREGS];
    logic [DATA_W-1:0] regs_nxt [NREGS];
    logic [PEND_W-1:0] pend     [NREGS];
    logic [PEND_W-1:0] pend_nxt [NREGS];
    logic [NREGS-1:0]  dec;
    logic [NREGS-1:0]  inc;
    logic              accept;

    assign wb_ready = (state == RUN);
    assign halted   = (state == HALT);
    assign accept   = wb_valid && (state == RUN);

    // In-flight register values (A > B > SP adjust) and writeback decrements
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_nxt[i] = regs[i];
            dec[i]      = 1'b0;
            if (accept) begin
                dec[i] = (wa_en && (wa_idx == IDX_W'(i))) || (wb_en && (wb_idx == IDX_W'(i)));
                if (wa_en && (wa_idx == IDX_W'(i))) begin
                    regs_nxt[i] = wa_data;
                end else if (wb_en && (wb_idx == IDX_W'(i))) begin
                    regs_nxt[i] = wb_data;
                end else if (IDX_W'(i) == IDX_W'(SP_IDX)) begin
                    if (sp_adj == 2'b01) begin
                        regs_nxt[i] = regs[i] + DATA_W'(SP_STEP);
                    end else if (sp_adj == 2'b10) begin
                        regs_nxt[i] = regs[i] - DATA_W'(SP_STEP);
                    end
                end
            end
        end
    end

    // A full counter refuses a reservation unless it is draining this cycle
    assign iss_stall = iss_valid && (pend[iss_idx] == PEND_MAX) && !dec[iss_idx];

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            inc[i]      = iss_valid && (iss_idx == IDX_W'(i)) && !iss_stall;
            pend_nxt[i] = pend[i];
            if (inc[i] && !dec[i]) begin
                pend_nxt[i] = pend[i] + PEND_W'(1);
            end else if (dec[i] && !inc[i] && (pend[i] != '0)) begin
                pend_nxt[i] = pend[i] - PEND_W'(1);
            end
        end
    end

    assign rd0_data = regs_nxt[rd0_idx];
    assign rd1_data = regs_nxt[rd1_idx];
    assign rd0_busy = (pend[rd0_idx] != '0) &&
                      !((pend[rd0_idx] == PEND_W'(1)) && dec[rd0_idx] && !inc[rd0_idx]);
    assign rd1_busy = (pend[rd1_idx] != '0) &&
                      !((pend[rd1_idx] == PEND_W'(1)) && dec[rd1_idx] && !inc[rd1_idx]);

    always_comb begin
        state_nxt = state;
        if (accept && sim_end) begin
            state_nxt = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= RUN;
            store_commit <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            store_commit <= accept && store_done;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= regs_nxt[i];
                pend[i] <= pend_nxt[i];
            end
        end
    end

    // Register 0 occupies the most significant slice
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_flat[(int'(NREGS) - 1 - i) * int'(DATA_W) +: int'(DATA_W)] = regs[i];
        end
    end

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Directed bench for wb_commit_regfile: a behavioural model checked every cycle
// plus literal expectations on the key scenarios.
module tb_wb_commit_regfile;

    logic          clk;
    logic          reset_n;
    logic          wb_valid;
    logic          wb_ready;
    logic          wa_en;
    logic [3:0]    wa_idx;
    logic [63:0]   wa_data;
    logic          wb_en;
    logic [3:0]    wb_idx;
    logic [63:0]   wb_data;
    logic [1:0]    sp_adj;
    logic          store_done;
    logic          sim_end;
    logic          iss_valid;
    logic [3:0]    iss_idx;
    logic          iss_stall;
    logic [3:0]    rd0_idx;
    logic [3:0]    rd1_idx;
    logic [63:0]   rd0_data;
    logic [63:0]   rd1_data;
    logic          rd0_busy;
    logic          rd1_busy;
    logic          store_commit;
    logic          halted;
    logic [1023:0] regs_flat;

    int n_tests = 0;
    int n_fail  = 0;

    wb_commit_regfile dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wa_en(wa_en), .wa_idx(wa_idx), .wa_data(wa_data),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .sp_adj(sp_adj), .store_done(store_done), .sim_end(sim_end),
        .iss_valid(iss_valid), .iss_idx(iss_idx), .iss_stall(iss_stall),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_busy(rd0_busy), .rd1_busy(rd1_busy), .store_commit(store_commit),
        .halted(halted), .regs_flat(regs_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] reg_of(input int i);
        return regs_flat[(15 - i) * 64 +: 64];
    endfunction

    // Behavioural model: architectural state as plain arrays and integers
    logic [63:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_halt;
    bit          m_sc;
    bit          m_ok = 1'b0;

    function automatic bit m_acc();
        return wb_valid && !m_halt;
    endfunction

    function automatic bit m_dec(input int i);
        return m_acc() && ((wa_en && int'(wa_idx) == i) || (wb_en && int'(wb_idx) == i));
    endfunction

    function automatic bit m_stall();
        return iss_valid && (m_cnt[int'(iss_idx)] == 3) && !m_dec(int'(iss_idx));
    endfunction

    function automatic bit m_inc(input int i);
        return iss_valid && (int'(iss_idx) == i) && !m_stall();
    endfunction

    // Apply effects lowest priority first so higher-priority writes overwrite
    function automatic logic [63:0] m_next(input int i);
        logic [63:0] v;
        v = m_regs[i];
        if (m_acc()) begin
            if (i == 4 && sp_adj == 2'b01) v = v + 64'd8;
            if (i == 4 && sp_adj == 2'b10) v = v - 64'd8;
            if (wb_en && int'(wb_idx) == i) v = wb_data;
            if (wa_en && int'(wa_idx) == i) v = wa_data;
        end
        return v;
    endfunction

    function automatic bit m_busy(input int i);
        return (m_cnt[i] != 0) && !(m_cnt[i] == 1 && m_dec(i) && !m_inc(i));
    endfunction

    always @(posedge clk) begin
        logic [63:0] t_regs [16];
        int          t_cnt  [16];
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
            m_halt = 1'b0;
            m_sc   = 1'b0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            for (int i = 0; i < 16; i++) begin
                t_regs[i] = m_next(i);
                t_cnt[i]  = m_cnt[i] + int'(m_inc(i)) - int'(m_dec(i));
                if (t_cnt[i] < 0) t_cnt[i] = 0;
            end
            m_sc = m_acc() && store_done;
            if (m_acc() && sim_end) m_halt = 1'b1;
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = t_regs[i];
                m_cnt[i]  = t_cnt[i];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), reg_of(i), m_regs[i]);
            chk("halted", 64'(halted), 64'(m_halt));
            chk("wb_ready", 64'(wb_ready), 64'(!m_halt));
            chk("store_commit", 64'(store_commit), 64'(m_sc));
            chk("rd0_data", rd0_data, m_next(int'(rd0_idx)));
            chk("rd1_data", rd1_data, m_next(int'(rd1_idx)));
            chk("rd0_busy", 64'(rd0_busy), 64'(m_busy(int'(rd0_idx))));
            chk("rd1_busy", 64'(rd1_busy), 64'(m_busy(int'(rd1_idx))));
            chk("iss_stall", 64'(iss_stall), 64'(m_stall()));
        end
    end

    task automatic idle();
        wb_valid = 0; wa_en = 0; wa_idx = 0; wa_data = 0; wb_en = 0; wb_idx = 0; wb_data = 0;
        sp_adj = 0; store_done = 0; sim_end = 0; iss_valid = 0; iss_idx = 0;
        rd0_idx = 0; rd1_idx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [3:0] idx, input logic [63:0] d);
        wb_valid = 1; wa_en = 1; wa_idx = idx; wa_data = d;
        tick();
        idle();
    endtask

    task automatic wb7();
        wb_valid = 1; wa_en = 1; wa_idx = 4'd7; wa_data = 64'h77; rd0_idx = 4'd7;
        tick();
        idle();
        rd0_idx = 4'd7;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_n = 0; wb_valid = 1; wa_en = 1; wa_idx = 4'd5; wa_data = 64'h55;
        tick();
        tick();
        reset_n = 1;
        idle();
        #1;
        chk("rst_reg5", reg_of(5), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_ready", 64'(wb_ready), 64'h1);
        chk("rst_store", 64'(store_commit), 64'h0);

        // Load with same-cycle bypass
        wb_valid = 1; wa_en = 1; wa_idx = 4'd3; wa_data = 64'hDEAD; rd0_idx = 4'd3;
        #1 chk("bypass_rd0", rd0_data, 64'hDEAD);
        tick();
        idle();
        #1 chk("load_reg3", reg_of(3), 64'hDEAD);

        // POP into SP: port A wins over adjust
        write_a(4'd4, 64'h1000);
        wb_valid = 1; wa_en = 1; wa_idx = 4'd4; wa_data = 64'h2000; sp_adj = 2'b01;
        tick();
        idle();
        #1 chk("pop_into_sp", reg_of(4), 64'h2000);
        write_a(4'd4, 64'h1000);
        wb_valid = 1; sp_adj = 2'b01; rd1_idx = 4'd4;
        #1 chk("pop_bypass", rd1_data, 64'h1008);
        tick();
        idle();
        #1 chk("pop_sp", reg_of(4), 64'h1008);
        write_a(4'd4, 64'h0);
        wb_valid = 1; sp_adj = 2'b10; store_done = 1;
        tick();
        idle();
        #1 chk("push_wrap", reg_of(4), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("store_pulse", 64'(store_commit), 64'h1);
        tick();
        chk("store_once", 64'(store_commit), 64'h0);

        // Dual write, then both ports on one register
        wb_valid = 1; wa_en = 1; wa_idx = 4'd0; wa_data = 64'h1;
        wb_en = 1; wb_idx = 4'd2; wb_data = 64'h5;
        tick();
        idle();
        #1 chk("imul_a", reg_of(0), 64'h1);
        chk("imul_b", reg_of(2), 64'h5);
        wb_valid = 1; wa_en = 1; wa_idx = 4'd6; wa_data = 64'hAAAA;
        wb_en = 1; wb_idx = 4'd6; wb_data = 64'hBBBB;
        tick();
        idle();
        #1 chk("same_idx_a_wins", reg_of(6), 64'hAAAA);

        // Scoreboard saturation and simultaneous reserve/writeback
        iss_valid = 1; iss_idx = 4'd7;
        tick();
        tick();
        tick();
        rd0_idx = 4'd7;
        #1 chk("sat_stall", 64'(iss_stall), 64'h1);
        chk("sat_busy", 64'(rd0_busy), 64'h1);
        tick();
        wb_valid = 1; wa_en = 1; wa_idx = 4'd7; wa_data = 64'h70;
        #1 chk("drain_no_stall", 64'(iss_stall), 64'h0);
        tick();
        idle();
        wb7();
        wb7();
        chk("busy_after_two", 64'(rd0_busy), 64'h1);
        wb_valid = 1; wa_en = 1; wa_idx = 4'd7; rd0_idx = 4'd7;
        #1 chk("busy_last_drain", 64'(rd0_busy), 64'h0);
        tick();
        idle();
        rd0_idx = 4'd7;
        #1 chk("busy_clear", 64'(rd0_busy), 64'h0);
        wb7();
        iss_valid = 1; iss_idx = 4'd7;
        tick();
        idle();
        rd0_idx = 4'd7;
        #1 chk("no_underflow", 64'(rd0_busy), 64'h1);
        wb7();
        chk("one_drained", 64'(rd0_busy), 64'h0);

        // Halt
        wb_valid = 1; wa_en = 1; wa_idx = 4'd1; wa_data = 64'h1111; sim_end = 1;
        tick();
        idle();
        #1 chk("halt_reg1", reg_of(1), 64'h1111);
        chk("halt_flag", 64'(halted), 64'h1);
        chk("halt_ready", 64'(wb_ready), 64'h0);
        wb_valid = 1; wa_en = 1; wa_idx = 4'd1; wa_data = 64'h2222; rd0_idx = 4'd1;
        #1 chk("halt_no_bypass", rd0_data, 64'h1111);
        tick();
        idle();
        #1 chk("halt_no_write", reg_of(1), 64'h1111);
        iss_valid = 1; iss_idx = 4'd9;
        tick();
        idle();
        rd1_idx = 4'd9;
        #1 chk("halt_reserve", 64'(rd1_busy), 64'h1);
        reset_n = 0;
        tick();
        reset_n = 1;
        #1 chk("rerun_halted", 64'(halted), 64'h0);
        chk("rerun_ready", 64'(wb_ready), 64'h1);
        chk("rerun_reg1", reg_of(1), 64'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
